// File: rtl/pdm_mic_interface.sv
// PDM microphone front end: programmable M_CLK divider with clean start/stop, L/R capture strobes.
// Define PDM_DECIM_EN to add a per-channel ones-count decimator (pcm_o / pcm_valid_o).
module pdm_mic_interface #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 32,
  parameter int CHANNELS    = 1,
  parameter int DECIM       = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             lr_sel_i,
  input  logic             M_DATA,
  output logic             M_CLK,
  output logic             M_LRSEL,
  output logic             busy_o,
  output logic [1:0]       bit_o,
  output logic [1:0]       bit_valid_o
`ifdef PDM_DECIM_EN
  ,
  output logic [1:0][$clog2(DECIM+1)-1:0] pcm_o,
  output logic [1:0]                      pcm_valid_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] d_eff, d_reg, half_m1, cnt;
  logic             sync1, sync2;
  logic             tog, cap_l, cap_r, start, want_l, want_r;
  logic [1:0]       ev;

  always_comb begin
    d_eff = {div_i[DIV_W-1:1], 1'b0};
    if (d_eff < DIV_W'(8)) d_eff = DIV_W'(8);
  end

  assign half_m1 = (d_reg >> 1) - 1'b1;
  assign tog     = (state != IDLE) && (cnt == half_m1);
  // M_CLK falling is the period boundary (L); rising is mid-period (R)
  assign cap_l   = tog && M_CLK;
  assign cap_r   = tog && !M_CLK;
  assign start   = (state == IDLE) && en_i;
  assign want_l  = (CHANNELS == 2) || !M_LRSEL;
  assign want_r  = (CHANNELS == 2) || M_LRSEL;
  assign ev      = {cap_r & want_r, cap_l & want_l};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      M_CLK       <= 1'b0;
      M_LRSEL     <= 1'b0;
      busy_o      <= 1'b0;
      bit_o       <= '0;
      bit_valid_o <= '0;
      d_reg       <= DIV_W'(DEFAULT_DIV);
      cnt         <= '0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
    end else begin
      sync1       <= M_DATA;
      sync2       <= sync1;
      bit_valid_o <= '0;
      case (state)
        IDLE: begin
          M_CLK   <= 1'b0;
          cnt     <= '0;
          M_LRSEL <= (CHANNELS == 1) ? lr_sel_i : 1'b0;
          if (en_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
            d_reg  <= d_eff;
          end
        end
        default: begin
          cnt <= tog ? '0 : cnt + 1'b1;
          if (tog)   M_CLK <= ~M_CLK;
          if (cap_l) d_reg <= d_eff;
          // RUN/STOP only differ in what happens at the boundary
          if (cap_l && !en_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state <= en_i ? RUN : STOP;
          end
          if (ev[0]) begin
            bit_o[0]       <= sync2;
            bit_valid_o[0] <= 1'b1;
          end
          if (ev[1]) begin
            bit_o[1]       <= sync2;
            bit_valid_o[1] <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PDM_DECIM_EN
  localparam int PW = $clog2(DECIM+1);

  logic [1:0][PW-1:0] ones, nbits;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ones        <= '0;
      nbits       <= '0;
      pcm_o       <= '0;
      pcm_valid_o <= '0;
    end else begin
      pcm_valid_o <= '0;
      for (int c = 0; c < 2; c++) begin
        if (start) begin
          ones[c]  <= '0;
          nbits[c] <= '0;
        end else if (ev[c]) begin
          if (nbits[c] == PW'(DECIM-1)) begin
            pcm_o[c]       <= ones[c] + PW'(sync2);
            pcm_valid_o[c] <= 1'b1;
            ones[c]        <= '0;
            nbits[c]       <= '0;
          end else begin
            ones[c]  <= ones[c] + PW'(sync2);
            nbits[c] <= nbits[c] + 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pdm_mic_interface.sv
// Bench for pdm_mic_interface: mono and stereo instances share stimulus and are checked
// each cycle against a period-position model, plus directed literal timing checks.
module tb_pdm_mic_interface;
  localparam int DIV_W = 8;
  localparam int DECIM = 128;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, lr_sel = 1'b0, mdata = 1'b0;
  logic [DIV_W-1:0] div = 8'd32;
  logic [1:0] mclk, lrsel, busy;
  logic [1:0][1:0] bo, bv;
`ifdef PDM_DECIM_EN
  localparam int PW = $clog2(DECIM+1);
  logic [1:0][1:0][PW-1:0] pcm;
  logic [1:0][1:0] pv;
`endif

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    pdm_mic_interface #(.DIV_W(DIV_W), .DEFAULT_DIV(32), .CHANNELS(k+1), .DECIM(DECIM)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .div_i(div), .lr_sel_i(lr_sel), .M_DATA(mdata),
      .M_CLK(mclk[k]), .M_LRSEL(lrsel[k]), .busy_o(busy[k]), .bit_o(bo[k]), .bit_valid_o(bv[k])
`ifdef PDM_DECIM_EN
      , .pcm_o(pcm[k]), .pcm_valid_o(pv[k])
`endif
    );
  end

  int checks = 0, errors = 0;
  bit cmp_en = 0, follow = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: each running instance tracks its position p within a period of D cycles;
  // M_CLK is high for the second half, L at the wrap, R at the midpoint.
  bit       m_run[2], m_mclk[2], m_lr[2], m_busy[2];
  int       m_p[2], m_d[2];
  bit [1:0] m_bo[2], m_bv[2], m_pv[2];
  int       m_ones[2][2], m_n[2][2], m_pcm[2][2];
  bit       dly[2];

  function automatic int eff_div(input int v);
    int d;
    d = v & ~1;
    return (d < 8) ? 8 : d;
  endfunction

  always @(posedge clk) begin
    bit s;
    bit [1:0] ev;
    s = dly[1];
    for (int k = 0; k < 2; k++) begin
      ev = '0;
      m_bv[k] = '0;
      m_pv[k] = '0;
      if (rst) begin
        m_run[k] = 0; m_p[k] = 0; m_d[k] = 32; m_mclk[k] = 0; m_lr[k] = 0;
        m_busy[k] = 0; m_bo[k] = '0;
        for (int c = 0; c < 2; c++) begin m_ones[k][c] = 0; m_n[k][c] = 0; m_pcm[k][c] = 0; end
      end else if (!m_run[k]) begin
        m_mclk[k] = 0;
        m_lr[k] = (k == 0) ? lr_sel : 1'b0;
        if (en) begin
          m_run[k] = 1; m_p[k] = 0; m_d[k] = eff_div(int'(div)); m_busy[k] = 1;
          for (int c = 0; c < 2; c++) begin m_ones[k][c] = 0; m_n[k][c] = 0; end
        end
      end else begin
        m_p[k]++;
        if (m_p[k] == m_d[k]) begin
          m_p[k] = 0;
          m_d[k] = eff_div(int'(div));
          ev[0] = (k == 1) || !m_lr[k];
          if (!en) begin m_run[k] = 0; m_busy[k] = 0; end
        end else if (m_p[k] == m_d[k] / 2) begin
          ev[1] = (k == 1) || m_lr[k];
        end
        m_mclk[k] = (m_p[k] >= m_d[k] / 2);
        for (int c = 0; c < 2; c++) if (ev[c]) begin
          m_bo[k][c] = s;
          m_bv[k][c] = 1;
          m_ones[k][c] += int'(s);
          m_n[k][c]++;
          if (m_n[k][c] == DECIM) begin
            m_pcm[k][c] = m_ones[k][c]; m_pv[k][c] = 1; m_ones[k][c] = 0; m_n[k][c] = 0;
          end
        end
      end
    end
    if (rst) begin dly[0] = 0; dly[1] = 0; end
    else begin dly[1] = dly[0]; dly[0] = mdata; end
  end

  always @(negedge clk) if (cmp_en) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mclk%0d", k),  int'(mclk[k]),  int'(m_mclk[k]));
      chk($sformatf("lrsel%0d", k), int'(lrsel[k]), int'(m_lr[k]));
      chk($sformatf("busy%0d", k),  int'(busy[k]),  int'(m_busy[k]));
      chk($sformatf("bit%0d", k),   int'(bo[k]),    int'(m_bo[k]));
      chk($sformatf("bitv%0d", k),  int'(bv[k]),    int'(m_bv[k]));
`ifdef PDM_DECIM_EN
      chk($sformatf("pcmv%0d", k),  int'(pv[k]),    int'(m_pv[k]));
      for (int c = 0; c < 2; c++) chk($sformatf("pcm%0d_%0d", k, c), int'(pcm[k][c]), m_pcm[k][c]);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (follow) mdata = mclk[1];
    end
  endtask

  task automatic wait_bv(input int k, input int c, output int n);
    n = 0;
    do begin tick(); n++; end while (!bv[k][c] && n < 1000);
    if (!bv[k][c]) chk("strobe_timeout", n, -1);
  endtask

  initial begin
    int n, cnt, hi;
    tick();
    cmp_en = 1;
    tick(2);
    rst = 0;
    // idle after reset
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mclk != 0 || busy != 0 || bv != 0) cnt++;
    end
    chk("reset_idle", cnt, 0);

    // mono L, D=32
    div = 8'd32; lr_sel = 0; mdata = 1; en = 1;
    wait_bv(0, 0, n); chk("mono_first_L", n, 33);
    wait_bv(0, 0, n); chk("mono_L_period", n, 32);
    chk("mono_L_bit", int'(bo[0][0]), 1);
    chk("mono_lrsel", int'(lrsel[0]), 0);
    hi = 0;
    for (int i = 0; i < 32; i++) begin tick(); hi += int'(mclk[0]); end
    chk("mono_high_half", hi, 16);

    // clamp and odd divider
    div = 8'd5;
    wait_bv(0, 0, n);
    wait_bv(0, 0, n); chk("clamp5", n, 8);
    div = 8'd33;
    wait_bv(0, 0, n);
    wait_bv(0, 0, n); chk("odd33", n, 32);
    // mid-period change only shows after the next boundary
    tick(5); div = 8'd64;
    wait_bv(0, 0, n); chk("mid_change_cur", n, 27);
    wait_bv(0, 0, n); chk("mid_change_new", n, 64);

    // stereo, M_DATA follows M_CLK
    div = 8'd8; follow = 1;
    wait_bv(1, 0, n);
    wait_bv(1, 1, n); chk("st_L2R", n, 4);
    chk("st_R_bit", int'(bo[1][1]), 0);
    wait_bv(1, 0, n); chk("st_R2L", n, 4);
    chk("st_L_bit", int'(bo[1][0]), 1);

    // stop mid-high-half
    follow = 0; mdata = 1;
    n = 0;
    while (!mclk[0] && n < 100) begin tick(); n++; end
    tick();
    en = 0;
    cnt = 0; n = 0;
    do begin tick(); n++; if (bv[0][0]) cnt++; end while (busy[0] && n < 100);
    chk("stop_final_L", cnt, 1);
    chk("stop_busy_low", int'(busy[0]), 0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin tick(); hi += int'(mclk[0]) + int'(busy[0]); end
    chk("stop_stays_low", hi, 0);

    // re-assert during STOP: no gap
    en = 1;
    wait_bv(0, 0, n);
    n = 0;
    while (!mclk[0] && n < 100) begin tick(); n++; end
    en = 0; tick(2); en = 1;
    cnt = 0; hi = 0;
    for (int i = 0; i < 40; i++) begin tick(); hi += int'(!busy[0]); cnt += int'(bv[0][0]); end
    chk("restart_no_gap", hi, 0);
    chk("restart_L_count", cnt, 5);

`ifdef PDM_DECIM_EN
    rst = 1; tick(); rst = 0;
    mdata = 1; div = 8'd8; lr_sel = 0; en = 1;
    n = 0;
    do begin tick(); n++; end while (!pv[0][0] && n < 3000);
    chk("pcm_first", int'(pcm[0][0]), 128);
    mdata = 0; n = 0;
    do begin tick(); n++; if (n % 8 == 0) mdata = ~mdata; end while (!pv[0][0] && n < 3000);
    chk("pcm_alt", int'(pcm[0][0]), 64);
    tick(200);
    rst = 1; tick(); rst = 0; mdata = 1;
    n = 0;
    do begin tick(); n++; end while (!pv[0][0] && n < 3000);
    chk("pcm_after_reset", int'(pcm[0][0]), 128);
    chk("pcm_after_reset_time", n, 1 + 128 * 8);
`endif

    // random soak
    en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) div = DIV_W'($urandom_range(0, 40));
      lr_sel = 1'($urandom_range(0, 1));
      mdata = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
